// File: rtl/nes_controller_emulator_pkg.sv
// Shared NES pad definitions: emulator state encoding, frame length and button bit positions.
// The button indices are also used by the console-side decoder.
package nes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } nes_emu_state_t;

    localparam int NES_BITS   = 8;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    // The pad line is active-low, so a pressed button (1) goes out as a 0.
    function automatic logic [NES_BITS-1:0] pad_image(input logic [NES_BITS-1:0] btn);
        return ~btn;
    endfunction

endpackage

// File: rtl/nes_controller_emulator_if.sv
// Pad connector signals between the console (master) and the controller (slave).
interface nes_controller_emulator_if;

    logic nes_latch;
    logic nes_pulse;
    logic nes_data;

    modport master (output nes_latch, output nes_pulse, input nes_data);
    modport slave  (input nes_latch, input nes_pulse, output nes_data);

endinterface

// File: rtl/nes_controller_emulator_sync_edge.sv
// Synchronizer for an asynchronous console pin, followed by one history flop for edge detection.
module nes_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/nes_controller_emulator.sv
// Controller-side NES pad: parallel-loads the buttons while the console latches,
// then shifts them out A-first on each console pulse.
module nes_controller_emulator
    import nes_pkg::*;
#(
    parameter int   SYNC_STAGES      = 2,
    parameter int   MIN_LATCH_CYCLES = 2,
    parameter logic FILL_LEVEL       = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NES_BITS-1:0]     buttons,
    nes_controller_emulator_if.slave pad,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int                 CNT_W     = $clog2(MIN_LATCH_CYCLES + 1);
    localparam logic [CNT_W-1:0]   LATCH_MIN = CNT_W'(MIN_LATCH_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]         LAST_BIT  = 4'(NES_BITS - 1);

    nes_emu_state_t       state;
    logic [NES_BITS-1:0]  shreg;
    logic [3:0]           bit_cnt;
    logic [CNT_W-1:0]     latch_cnt;

    logic lat_s, lat_rise, lat_fall;
    logic pul_s, pul_rise, pul_fall;

    nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pad.nes_latch),
        .level    (lat_s),
        .rise     (lat_rise),
        .fall     (lat_fall)
    );

    nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pad.nes_pulse),
        .level    (pul_s),
        .rise     (pul_rise),
        .fall     (pul_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, lat_rise, lat_fall, pul_s, pul_fall};

    // Latch is checked before the pulse in every state, so a coincident pulse is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= 8'hFF;
            bit_cnt    <= 4'd0;
            latch_cnt  <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (lat_s) begin
                        state     <= LOAD;
                        latch_cnt <= CNT_ONE;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    shreg <= pad_image(buttons);
                    if (latch_cnt < LATCH_MIN) begin
                        latch_cnt <= latch_cnt + CNT_ONE;
                    end
                    if (!lat_s) begin
                        if (latch_cnt >= LATCH_MIN) begin
                            state   <= SHIFT;
                            bit_cnt <= 4'd0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    if (lat_s) begin
                        state     <= LOAD;
                        latch_cnt <= CNT_ONE;
                    end else if (pul_rise) begin
                        shreg   <= {shreg[NES_BITS-2:0], FILL_LEVEL};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                            busy       <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (lat_s) begin
                        state     <= LOAD;
                        latch_cnt <= CNT_ONE;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pad.nes_data = shreg[NES_BITS-1];

endmodule

// File: tb/tb_nes_controller_emulator.sv
// Self-checking bench for nes_controller_emulator: a per-cycle frame model plus directed literal checks.
module tb_nes_controller_emulator;
    import nes_pkg::*;

    localparam int   SYNC = 2;
    localparam int   MINL = 2;
    localparam logic FILL = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] buttons;
    logic       frame_done;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int fd_count = 0;

    nes_controller_emulator_if pad ();

    nes_controller_emulator #(
        .SYNC_STAGES      (SYNC),
        .MIN_LATCH_CYCLES (MINL),
        .FILL_LEVEL       (FILL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .buttons    (buttons),
        .pad        (pad),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the block sees each pin SYNC edges late; a frame is the inverted button byte
    // captured when the latch is released, exposed one bit per accepted pulse, then FILL.
    logic      lh [0:SYNC-1];
    logic      ph [0:SYNC];
    int        mode;
    int        run;
    int        idx;
    logic [7:0] frame;
    logic      exp_fd;
    bit        model_valid = 1'b0;

    always @(posedge clk) begin
        logic ls, prise;
        if (reset) begin
            for (int i = 0; i < SYNC; i++) lh[i] = 1'b0;
            for (int i = 0; i <= SYNC; i++) ph[i] = 1'b0;
            mode = 0; run = 0; idx = 0; frame = 8'hFF; exp_fd = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            ls    = lh[SYNC-1];
            prise = ph[SYNC-1] & ~ph[SYNC];
            for (int i = SYNC-1; i > 0; i--) lh[i] = lh[i-1];
            lh[0] = pad.nes_latch;
            for (int i = SYNC; i > 0; i--) ph[i] = ph[i-1];
            ph[0] = pad.nes_pulse;
            exp_fd = 1'b0;
            if (ls) begin
                if (mode != 1) begin
                    mode = 1; run = 1;
                end else begin
                    run++; frame = ~buttons; idx = 0;
                end
            end else if (mode == 1) begin
                frame = ~buttons; idx = 0;
                mode = (run >= MINL) ? 2 : 0;
            end else if (mode == 2 && prise) begin
                idx++;
                if (idx == 8) begin
                    mode = 0; exp_fd = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("model nes_data", pad.nes_data, (idx < 8) ? frame[7-idx] : FILL);
            checkOutput("model busy", busy, (mode != 0));
            checkOutput("model frame_done", frame_done, exp_fd);
            if (frame_done === 1'b1) fd_count++;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic l, input logic p, input logic [7:0] b);
        pad.nes_latch = l;
        pad.nes_pulse = p;
        buttons       = b;
    endtask

    task automatic latchPad(input int n);
        pad.nes_latch = 1'b1;
        waitCycles(n);
        pad.nes_latch = 1'b0;
        waitCycles(6);
    endtask

    task automatic pulsePad();
        pad.nes_pulse = 1'b1;
        waitCycles(5);
        pad.nes_pulse = 1'b0;
        waitCycles(5);
    endtask

    // Sends a full frame, checking each line level against a hand-written expected bit sequence.
    task automatic sendFrame(input string tag, input logic [7:0] seq);
        checkOutput({tag, " bit0"}, pad.nes_data, seq[7]);
        for (int k = 0; k < 8; k++) begin
            pulsePad();
            checkOutput($sformatf("%s after pulse %0d", tag, k + 1), pad.nes_data,
                        (k < 7) ? seq[6-k] : FILL);
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        waitCycles(3);
        checkOutput("reset nes_data", pad.nes_data, 1'b1);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset frame_done", frame_done, 1'b0);
        reset = 1'b0;
        waitCycles(2);

        $display("[TB] test 1: basic frame");
        buttons = 8'b1001_0001;
        fd_count = 0;
        latchPad(4);
        checkOutput("t1 busy", busy, 1'b1);
        sendFrame("t1", 8'b0110_1110);
        checkOutput("t1 frame_done count", fd_count, 1);
        checkOutput("t1 busy after", busy, 1'b0);

        $display("[TB] test 2: short latch rejected");
        buttons = 8'h00;
        fd_count = 0;
        latchPad(1);
        checkOutput("t2 busy", busy, 1'b0);
        checkOutput("t2 loaded line", pad.nes_data, 1'b1);
        for (int k = 0; k < 8; k++) pulsePad();
        checkOutput("t2 line constant", pad.nes_data, 1'b1);
        checkOutput("t2 frame_done count", fd_count, 0);

        $display("[TB] test 3: aborted frame then full frame");
        buttons = 8'hFF;
        fd_count = 0;
        latchPad(4);
        for (int k = 0; k < 3; k++) pulsePad();
        checkOutput("t3 partial line", pad.nes_data, 1'b0);
        checkOutput("t3 no frame_done", fd_count, 0);
        buttons = 8'h00;
        latchPad(4);
        sendFrame("t3", 8'hFF);
        checkOutput("t3 frame_done count", fd_count, 1);

        $display("[TB] test 4: latch and pulse together");
        fd_count = 0;
        applyStimulus(1'b1, 1'b1, 8'h7F);
        waitCycles(4);
        applyStimulus(1'b0, 1'b0, 8'h7F);
        waitCycles(6);
        checkOutput("t4 A presented", pad.nes_data, 1'b1);
        checkOutput("t4 busy", busy, 1'b1);
        pulsePad();
        checkOutput("t4 B after pulse", pad.nes_data, 1'b0);
        checkOutput("t4 no frame_done", fd_count, 0);

        $display("[TB] test 5: reset mid-frame");
        buttons = 8'b1001_0001;
        latchPad(4);
        for (int k = 0; k < 5; k++) pulsePad();
        reset = 1'b1;
        waitCycles(1);
        checkOutput("t5 reset nes_data", pad.nes_data, 1'b1);
        checkOutput("t5 reset busy", busy, 1'b0);
        checkOutput("t5 reset frame_done", frame_done, 1'b0);
        reset = 1'b0;
        waitCycles(2);
        fd_count = 0;
        latchPad(4);
        sendFrame("t5", 8'b0110_1110);
        checkOutput("t5 frame_done count", fd_count, 1);

        $display("[TB] test 6: buttons change during shift");
        buttons = 8'h00;
        fd_count = 0;
        latchPad(4);
        buttons = 8'h80;
        sendFrame("t6", 8'hFF);
        checkOutput("t6 frame_done count", fd_count, 1);
        latchPad(4);
        checkOutput("t6 next frame A", pad.nes_data, 1'b0);

        waitCycles(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
